sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM master port (read_en / write_en / address / writeData / datareadvalid) between two requesters: the pixel-read path (window buffer fill) and the pixel-write path (processed output).
- Writes are posted into a small FIFO so the filter pipeline never stalls on a single write.
- Reads are blocking request/response transactions.
- Arbitration is round-robin, with read-after-write hazard protection.

Parameters:
- ADDR_W, 26, SDRAM word address width
- DATA_W, 32, SDRAM data width (ARGB pixel)
- WBUF_DEPTH, 4, posted-write FIFO depth (power of 2, at least 2)
- RD_TIMEOUT, 255, maximum cycles to wait for sdram_datareadvalid

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rd_req  in  1  read request; held high with rd_addr stable until rd_valid
- rd_addr  in  ADDR_W  read word address
- rd_valid  out  1  one-cycle pulse; rd_data/rd_error valid
- rd_data  out  DATA_W  returned read data
- rd_error  out  1  read timed out (qualified by rd_valid)
- wr_push  in  1  enqueue write; ignored when wr_full
- wr_addr  in  ADDR_W  write word address
- wr_data  in  DATA_W  write data
- wr_full  out  1  FIFO holds WBUF_DEPTH entries
- wr_empty  out  1  FIFO empty and no write in flight
- sdram_read_en  out  1  read strobe
- sdram_write_en  out  1  write strobe
- address_sdram  out  ADDR_W  SDRAM address
- writeData_sdram  out  DATA_W  SDRAM write data
- data_sdram  in  DATA_W  SDRAM read data
- sdram_datareadvalid  in  1  read data valid strobe

Behaviour:
- One clock (clk); reset is asynchronous and active-low (n_rst).
- All outputs are registered. Reset values:
  - 0: rd_valid, rd_data, rd_error, sdram_read_en, sdram_write_en, address_sdram, writeData_sdram, wr_full.
  - 1: wr_empty.
  - Other state: FIFO pointers 0, state IDLE, last_grant=WRITE.
- FIFO: write side on wr_push && !wr_full; read-side pop at end of WR_ISSUE. Simultaneous push and pop in the same cycle is legal; count is unchanged. A push while full is dropped with no corruption.
- States:
  - IDLE: selects the next transaction (rules below).
  - RD_ISSUE: sdram_read_en=1 for exactly one cycle; address_sdram=latched rd_addr.
  - RD_WAIT: sdram_read_en=0, address held. On sdram_datareadvalid, rd_data<=data_sdram. The next cycle gives rd_valid=1 and rd_error=0, then IDLE. If the timeout counter reaches RD_TIMEOUT first: rd_valid=1, rd_error=1, rd_data=0, then IDLE.
  - WR_ISSUE: sdram_write_en=1 for one cycle with address/data from the FIFO head; pop; then IDLE. Writes complete in one cycle.
- IDLE selection, in priority order:
  1. rd_req and rd_addr equal to any valid FIFO entry address (hazard): write.
  2. wr_full: write.
  3. Both pending: grant the opposite of last_grant.
  4. Only one pending: grant it.
  5. Neither pending: stay IDLE.
- IDLE is a full decision cycle: minimum read latency from rd_req to rd_valid is 3 cycles plus the SDRAM latency. Back-to-back writes occupy alternate cycles (IDLE, WR_ISSUE).
- In IDLE, address_sdram and writeData_sdram hold their last values and both strobes are 0. Strobes are never high simultaneously.
- sdram_datareadvalid outside RD_WAIT is ignored.
- rd_req dropping mid-transaction is illegal; the bench asserts against it.
- wr_empty=1 only when the FIFO count is 0 and the state is not WR_ISSUE. The top level gates finish_flag on it.
- Reset mid-operation returns to IDLE immediately. The FIFO is discarded and strobes drop asynchronously.

Decomposition:
- Package sdram_arb_pkg:
  - typedef arb_state_t {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE};
  - typedef grant_t {GRANT_READ, GRANT_WRITE};
  - ADDR_W/DATA_W defaults.
- One sub-module: sdram_wr_fifo. A parameterised FIFO exposing the head entry, count, full/empty, and a per-entry address-match vector for the hazard check.

Test Plan:
- Single read, rd_addr=0x000010, sdram_datareadvalid 2 cycles after strobe with data 0xFF102030 -> one-cycle sdram_read_en, address 0x000010, rd_valid with rd_data=0xFF102030, rd_error=0.
- Push 4 writes (addr 0..3, data 0xA0..0xA3) back-to-back -> wr_full=1 after the 4th; a 5th push is dropped; 4 write strobes in order, 2 cycles apart; wr_empty=1 after the last.
- rd_req continuously plus a write stream -> grants alternate R,W,R,W; no strobe overlap.
- Buffered write to 0x000020, then rd_req at 0x000020 -> write strobe precedes the read strobe.
- No datareadvalid after a read strobe -> rd_valid with rd_error=1 and rd_data=0, RD_TIMEOUT+1 cycles after the strobe.
- n_rst asserted in RD_WAIT with 2 writes queued -> all outputs at reset values, wr_empty=1, no stale strobe after release.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM port arbiter and its posted-write FIFO.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} arb_state_t;
  typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Posted-write FIFO: exposes the head entry, occupancy, registered full/empty flags
// and a per-entry address-match vector used for read-after-write hazard detection.
module sdram_wr_fifo
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      push,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  input  logic [ADDR_W-1:0]         cmp_addr,
  output logic [ADDR_W-1:0]         head_addr,
  output logic [DATA_W-1:0]         head_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0]          addr_match
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count_nxt;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Only slots between rd_ptr and rd_ptr+count hold live writes; stale slots must not match.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset     = '0;
    addr_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - rd_ptr;
      addr_match[i] = ({1'b0, offset} < count) && (addr_mem[i] == cmp_addr);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM master port between a blocking pixel-read path and a posted
// pixel-write path, round-robin with read-after-write hazard protection.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WBUF_DEPTH = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_error,
  input  logic              wr_push,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  output logic              wr_empty,
  output logic              sdram_read_en,
  output logic              sdram_write_en,
  output logic [ADDR_W-1:0] address_sdram,
  output logic [DATA_W-1:0] writeData_sdram,
  input  logic [DATA_W-1:0] data_sdram,
  input  logic              sdram_datareadvalid
);

  localparam int CNT_W  = $clog2(RD_TIMEOUT + 1);
  localparam int FCNT_W = $clog2(WBUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RD_TIMEOUT);
  localparam logic [CNT_W-1:0] TO_ONE  = CNT_W'(1);

  arb_state_t state, state_nxt;
  grant_t     last_grant, last_grant_nxt;

  logic [CNT_W-1:0]      to_cnt;
  logic [ADDR_W-1:0]     fifo_head_addr;
  logic [DATA_W-1:0]     fifo_head_data;
  logic [FCNT_W-1:0]     fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [WBUF_DEPTH-1:0] addr_match;
  logic                  rd_pending;
  logic                  wr_pending;
  logic                  hazard;
  logic                  rd_done;
  logic                  rd_timeout;

  sdram_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wr_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .push       (wr_push),
    .push_addr  (wr_addr),
    .push_data  (wr_data),
    .pop        (state == WR_ISSUE),
    .cmp_addr   (rd_addr),
    .head_addr  (fifo_head_addr),
    .head_data  (fifo_head_data),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .addr_match (addr_match)
  );

  // The entry being popped is still counted during WR_ISSUE, so empty already excludes it.
  assign wr_full  = fifo_full;
  assign wr_empty = fifo_empty;

  // The requester still holds rd_req during the rd_valid cycle; that request is already served.
  assign rd_pending = rd_req && !rd_valid;
  assign wr_pending = (fifo_count != '0);
  assign hazard     = rd_pending && (|addr_match);
  assign rd_done    = (state == RD_WAIT) && sdram_datareadvalid;
  assign rd_timeout = (state == RD_WAIT) && !sdram_datareadvalid && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (wr_pending && (hazard || fifo_full || !rd_pending || last_grant == GRANT_READ)) begin
          state_nxt      = WR_ISSUE;
          last_grant_nxt = GRANT_WRITE;
        end else if (rd_pending) begin
          state_nxt      = RD_ISSUE;
          last_grant_nxt = GRANT_READ;
        end
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (rd_done || rd_timeout) state_nxt = IDLE;
      WR_ISSUE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // to_cnt counts cycles since the read strobe: 1 in the first RD_WAIT cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= IDLE;
      last_grant      <= GRANT_WRITE;
      to_cnt          <= '0;
      rd_valid        <= 1'b0;
      rd_data         <= '0;
      rd_error        <= 1'b0;
      sdram_read_en   <= 1'b0;
      sdram_write_en  <= 1'b0;
      address_sdram   <= '0;
      writeData_sdram <= '0;
    end else begin
      state          <= state_nxt;
      last_grant     <= last_grant_nxt;
      sdram_read_en  <= (state_nxt == RD_ISSUE);
      sdram_write_en <= (state_nxt == WR_ISSUE);
      rd_valid       <= rd_done || rd_timeout;
      rd_error       <= rd_timeout;
      if (rd_done)         rd_data <= data_sdram;
      else if (rd_timeout) rd_data <= '0;
      if (state == RD_ISSUE)     to_cnt <= TO_ONE;
      else if (state == RD_WAIT) to_cnt <= to_cnt + TO_ONE;
      if (state_nxt == RD_ISSUE) begin
        address_sdram <= rd_addr;
      end else if (state_nxt == WR_ISSUE) begin
        address_sdram   <= fifo_head_addr;
        writeData_sdram <= fifo_head_data;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: stimulus queues expected strobes and
// responses, a negedge monitor pops and compares whatever the DUT presents.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int RD_TO  = 255;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_error;
  logic              wr_push;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic              wr_empty;
  logic              sdram_read_en;
  logic              sdram_write_en;
  logic [ADDR_W-1:0] address_sdram;
  logic [DATA_W-1:0] writeData_sdram;
  logic [DATA_W-1:0] data_sdram;
  logic              sdram_datareadvalid;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(DEPTH), .RD_TIMEOUT(RD_TO)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_error(rd_error), .wr_push(wr_push), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_full(wr_full), .wr_empty(wr_empty), .sdram_read_en(sdram_read_en),
    .sdram_write_en(sdram_write_en), .address_sdram(address_sdram),
    .writeData_sdram(writeData_sdram), .data_sdram(data_sdram),
    .sdram_datareadvalid(sdram_datareadvalid)
  );

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; int gap; } wr_exp_t;
  typedef struct { logic [DATA_W-1:0] data; logic err; int lat; } rd_exp_t;

  wr_exp_t           wr_q[$];
  rd_exp_t           rsp_q[$];
  logic [ADDR_W-1:0] rda_q[$];
  bit                kind_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int last_wr_cyc = 0;
  int mem_lat = 0;
  logic [DATA_W-1:0] mem_data = '0;
  bit rd_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
  endtask

  task automatic exp_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic e, input int lat, input bit has_rsp);
    rd_exp_t r;
    kind_q.push_back(1'b0);
    rda_q.push_back(a);
    if (has_rsp) begin
      r.data = d; r.err = e; r.lat = lat;
      rsp_q.push_back(r);
    end
  endtask

  task automatic exp_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int gap);
    wr_exp_t w;
    w.addr = a; w.data = d; w.gap = gap;
    kind_q.push_back(1'b1);
    wr_q.push_back(w);
  endtask

  task automatic wait_rd_strobe(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sdram_read_en) return;
    end
    fail_now(name, $sformatf("no read strobe within %0d cycles", max_cyc));
  endtask

  task automatic wait_rd_valid(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rd_valid) return;
    end
    fail_now(name, $sformatf("no rd_valid within %0d cycles", max_cyc));
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (kind_q.size() == 0 && rsp_q.size() == 0) return;
    end
    fail_now(name, $sformatf("%0d strobes and %0d responses still outstanding",
                             kind_q.size(), rsp_q.size()));
  endtask

  task automatic push_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    wr_push = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
    chk({tag, "_rd_data"}, 64'(rd_data), 64'(0));
    chk({tag, "_rd_error"}, 64'(rd_error), 64'(0));
    chk({tag, "_read_en"}, 64'(sdram_read_en), 64'(0));
    chk({tag, "_write_en"}, 64'(sdram_write_en), 64'(0));
    chk({tag, "_address"}, 64'(address_sdram), 64'(0));
    chk({tag, "_wdata"}, 64'(writeData_sdram), 64'(0));
    chk({tag, "_wr_full"}, 64'(wr_full), 64'(0));
    chk({tag, "_wr_empty"}, 64'(wr_empty), 64'(1));
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  always @(posedge clk)
    if (n_rst) assert (!rd_pend || rd_req) else $error("rd_req dropped mid-transaction");

  // SDRAM model: answers a read strobe mem_lat cycles later; mem_lat 0 never answers.
  initial begin
    sdram_datareadvalid = 1'b0;
    data_sdram = '0;
    forever begin
      @(posedge clk); #1;
      if (sdram_read_en && mem_lat > 0) begin
        repeat (mem_lat) @(posedge clk);
        #1;
        sdram_datareadvalid = 1'b1;
        data_sdram = mem_data;
        @(posedge clk); #1;
        sdram_datareadvalid = 1'b0;
        data_sdram = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (sdram_read_en || sdram_write_en) begin
      chk("strobe_overlap", 64'(sdram_read_en && sdram_write_en), 64'(0));
      if (kind_q.size() == 0)
        fail_now("strobe_unexpected", $sformatf("rd=%0b wr=%0b addr=0x%0h",
                 sdram_read_en, sdram_write_en, address_sdram));
      else
        chk("strobe_kind_is_write", 64'(sdram_write_en), 64'(kind_q.pop_front()));
      if (sdram_write_en) begin
        if (wr_q.size() == 0) begin
          fail_now("wr_unexpected", $sformatf("addr=0x%0h", address_sdram));
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          chk("wr_addr", 64'(address_sdram), 64'(w.addr));
          chk("wr_data", 64'(writeData_sdram), 64'(w.data));
          if (w.gap > 0) chk("wr_gap", 64'(cyc - last_wr_cyc), 64'(w.gap));
        end
        last_wr_cyc = cyc;
      end else if (sdram_read_en) begin
        if (rda_q.size() == 0) fail_now("rd_unexpected", $sformatf("addr=0x%0h", address_sdram));
        else chk("rd_addr", 64'(address_sdram), 64'(rda_q.pop_front()));
        last_rd_cyc = cyc;
      end
    end
    if (rd_valid) begin
      if (rsp_q.size() == 0) begin
        fail_now("rsp_unexpected", $sformatf("data=0x%0h err=%0b", rd_data, rd_error));
      end else begin
        rd_exp_t r;
        r = rsp_q.pop_front();
        chk("rsp_data", 64'(rd_data), 64'(r.data));
        chk("rsp_error", 64'(rd_error), 64'(r.err));
        chk("rsp_latency", 64'(cyc - last_rd_cyc), 64'(r.lat));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wr_push = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // single read, data two cycles after the strobe
    mem_lat = 2; mem_data = 32'hFF10_2030;
    exp_read(26'h10, 32'hFF10_2030, 1'b0, 3, 1'b1);
    rd_req = 1'b1; rd_addr = 26'h10; rd_pend = 1'b1;
    wait_rd_valid(20, "single_rd_valid");
    rd_pend = 1'b0; rd_req = 1'b0;
    wait_drain(20, "single_drain");

    // fill the FIFO while a long read holds the port
    mem_lat = 10; mem_data = 32'hCAFE_F00D;
    exp_read(26'h100, 32'hCAFE_F00D, 1'b0, 11, 1'b1);
    for (int i = 0; i < 4; i++) exp_write(ADDR_W'(i), 32'hA0 + 32'(i), (i == 0) ? 0 : 2);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 26'h100; rd_pend = 1'b1;
    wait_rd_strobe(10, "fill_rd_strobe");
    for (int i = 0; i < 4; i++) push_write(ADDR_W'(i), 32'hA0 + 32'(i));
    @(negedge clk);
    chk("fill_wr_full", 64'(wr_full), 64'(1));
    chk("fill_wr_empty", 64'(wr_empty), 64'(0));
    wr_push = 1'b1; wr_addr = 26'h3F; wr_data = 32'hEE;
    @(negedge clk);
    wr_push = 1'b0;
    chk("fill_wr_full_after_drop", 64'(wr_full), 64'(1));
    wait_rd_valid(20, "fill_rd_valid");
    rd_pend = 1'b0; rd_req = 1'b0;
    wait_drain(30, "fill_drain");
    @(negedge clk);
    chk("drained_wr_empty", 64'(wr_empty), 64'(1));
    chk("drained_wr_full", 64'(wr_full), 64'(0));

    // read-after-write hazard: buffered write must reach SDRAM before the read
    mem_lat = 1; mem_data = 32'h1234_5678;
    exp_write(26'h20, 32'h5555_AAAA, 0);
    exp_read(26'h20, 32'h1234_5678, 1'b0, 2, 1'b1);
    push_write(26'h20, 32'h5555_AAAA);
    @(negedge clk);
    wr_push = 1'b0;
    rd_req = 1'b1; rd_addr = 26'h20; rd_pend = 1'b1;
    wait_rd_valid(20, "hazard_rd_valid");
    rd_pend = 1'b0; rd_req = 1'b0;
    wait_drain(20, "hazard_drain");

    // continuous reads against a write backlog alternate R,W,R,W,R,W
    mem_lat = 4; mem_data = 32'h1111_0080;
    exp_read(26'h80, 32'h1111_0080, 1'b0, 5, 1'b1);
    exp_write(26'h40, 32'hB0, 0);
    exp_read(26'h81, 32'h2222_0081, 1'b0, 2, 1'b1);
    exp_write(26'h41, 32'hB1, 0);
    exp_read(26'h82, 32'h3333_0082, 1'b0, 2, 1'b1);
    exp_write(26'h42, 32'hB2, 0);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 26'h80; rd_pend = 1'b1;
    wait_rd_strobe(10, "alt_rd_strobe");
    for (int i = 0; i < 3; i++) push_write(26'h40 + ADDR_W'(i), 32'hB0 + 32'(i));
    @(negedge clk);
    wr_push = 1'b0;
    wait_rd_valid(20, "alt_rd_valid_a");
    rd_addr = 26'h81; mem_data = 32'h2222_0081; mem_lat = 1;
    wait_rd_valid(20, "alt_rd_valid_b");
    rd_addr = 26'h82; mem_data = 32'h3333_0082;
    wait_rd_valid(20, "alt_rd_valid_c");
    rd_pend = 1'b0; rd_req = 1'b0;
    wait_drain(20, "alt_drain");

    // read timeout: no datareadvalid ever arrives
    mem_lat = 0;
    exp_read(26'h30, 32'h0, 1'b1, RD_TO + 1, 1'b1);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 26'h30; rd_pend = 1'b1;
    wait_rd_valid(RD_TO + 20, "timeout_rd_valid");
    rd_pend = 1'b0; rd_req = 1'b0;
    wait_drain(20, "timeout_drain");

    // reset in RD_WAIT with two writes queued discards everything
    exp_read(26'h50, 32'h0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 26'h50; rd_pend = 1'b1;
    wait_rd_strobe(10, "rst_rd_strobe");
    push_write(26'h60, 32'hC0);
    push_write(26'h61, 32'hC1);
    @(negedge clk);
    wr_push = 1'b0;
    @(negedge clk);
    chk("rst_pre_wr_empty", 64'(wr_empty), 64'(0));
    rd_pend = 1'b0; rd_req = 1'b0;
    n_rst = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_wr_empty", 64'(wr_empty), 64'(1));
    chk("post_rst_strobes_left", 64'(kind_q.size()), 64'(0));
    chk("post_rst_rsp_left", 64'(rsp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
